// File: rtl/bp_update.sv
// Branch-predictor update path: resolves outcomes, raises fetch redirects on
// mispredicts and queues PHT/BTB writes through a small drain FIFO.
module bp_update #(
  parameter int unsigned PC_W       = 32,
  parameter int unsigned PHT_IDX_W  = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 res_valid,
  output logic                 res_ready,
  input  logic [PC_W-1:0]      res_pc,
  input  logic                 res_is_cond,
  input  logic                 res_taken,
  input  logic [PC_W-1:0]      res_target,
  input  logic                 res_pred_taken,
  input  logic [1:0]           res_pred_state,
  input  logic                 res_btb_hit,
  input  logic [PC_W-1:0]      res_pred_target,
  output logic                 redirect_valid,
  output logic [PC_W-1:0]      redirect_pc,
  output logic                 pht_we,
  output logic [PHT_IDX_W-1:0] pht_waddr,
  output logic [1:0]           pht_wdata,
  output logic                 btb_we,
  output logic [PC_W-1:0]      btb_wpc,
  output logic [PC_W-1:0]      btb_wtarget,
  input  logic                 upd_stall,
  output logic [31:0]          mispredict_cnt
);

  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned IDX_LSB = 3;

  typedef struct packed {
    logic                 pht_req;
    logic [PHT_IDX_W-1:0] idx;
    logic [1:0]           new_state;
    logic                 btb_req;
    logic [PC_W-1:0]      pc;
    logic [PC_W-1:0]      target;
  } upd_entry_t;

  upd_entry_t           fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 ready_q;

  logic                 accept_c;
  logic                 target_miss_c;
  logic                 mispredict_c;
  logic [1:0]           new_state_c;
  logic                 push_c;
  logic                 pop_c;
  logic [CNT_W-1:0]     count_next_c;
  upd_entry_t           entry_c;
  upd_entry_t           head_c;

  assign res_ready = ready_q;

  // Resolution classification and next PHT counter value
  always_comb begin
    accept_c      = res_valid && ready_q;
    target_miss_c = !res_btb_hit || (res_pred_target != res_target);
    mispredict_c  = (res_taken != res_pred_taken) || (res_taken && target_miss_c);
    new_state_c   = res_pred_state;
    if (res_taken) begin
      if (res_pred_state != 2'd3) new_state_c = res_pred_state + 2'd1;
    end else begin
      if (res_pred_state != 2'd0) new_state_c = res_pred_state - 2'd1;
    end
  end

  always_comb begin
    entry_c           = '0;
    entry_c.pht_req   = res_is_cond;
    entry_c.idx       = res_pc[IDX_LSB +: PHT_IDX_W];
    entry_c.new_state = new_state_c;
    entry_c.btb_req   = res_taken && target_miss_c;
    entry_c.pc        = res_pc;
    entry_c.target    = res_target;
  end

  // Occupancy bookkeeping; ready is registered from the post-edge occupancy
  always_comb begin
    push_c       = accept_c && (entry_c.pht_req || entry_c.btb_req);
    pop_c        = (count != '0) && !upd_stall;
    head_c       = fifo_mem[rd_ptr];
    count_next_c = count;
    case ({push_c, pop_c})
      2'b10:   count_next_c = count + CNT_W'(1);
      2'b01:   count_next_c = count - CNT_W'(1);
      default: count_next_c = count;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_mem[i] <= '0;
    end else if (push_c) begin
      fifo_mem[wr_ptr] <= entry_c;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count   <= count_next_c;
      ready_q <= (count_next_c != CNT_W'(FIFO_DEPTH));
    end
  end

  // Write ports pulse for one cycle after each pop; data holds between pulses
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pht_we      <= 1'b0;
      btb_we      <= 1'b0;
      pht_waddr   <= '0;
      pht_wdata   <= '0;
      btb_wpc     <= '0;
      btb_wtarget <= '0;
    end else begin
      pht_we <= pop_c && head_c.pht_req;
      btb_we <= pop_c && head_c.btb_req;
      if (pop_c) begin
        pht_waddr   <= head_c.idx;
        pht_wdata   <= head_c.new_state;
        btb_wpc     <= head_c.pc;
        btb_wtarget <= head_c.target;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= accept_c && mispredict_c;
      if (accept_c && mispredict_c) begin
        redirect_pc <= res_taken ? res_target : PC_W'(res_pc + PC_W'(4));
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mispredict_cnt <= '0;
    end else if (accept_c && mispredict_c && (mispredict_cnt != 32'hFFFF_FFFF)) begin
      mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end

endmodule
